// File: rtl/hazard_scheduler_20_if.sv
// hazard_scheduler_20_if
// Pipeline-side signal bundle for the hazard scheduler. The master side is
// the pipeline datapath, which presents decode, execute, memory and
// writeback status. The slave side is the scheduler, which returns
// stall/flush controls, the registered forward selects and the delayed
// writeback result.
interface hazard_scheduler_20_if;
  // Decode stage
  logic        ValidD;
  logic [2:0]  RS1_D;
  logic [2:0]  RS2_D;
  logic        UseRS1D;
  logic        UseRS2D;
  // Execute stage
  logic [2:0]  RD_E;
  logic        RegWriteE;
  logic        ResultSrcE;
  logic        PCSrcE;
  // Memory stage
  logic [2:0]  RD_M;
  logic        RegWriteM;
  // Writeback stage
  logic [2:0]  RDW;
  logic        RegWriteW;
  logic [23:0] ResultW;
  // Scheduler outputs
  logic        StallF;
  logic        StallD;
  logic        FlushD;
  logic        FlushE;
  logic [1:0]  ForwardAE;
  logic [1:0]  ForwardBE;
  logic [23:0] ResultW_q;

  modport master (
    output ValidD, RS1_D, RS2_D, UseRS1D, UseRS2D,
    output RD_E, RegWriteE, ResultSrcE, PCSrcE,
    output RD_M, RegWriteM,
    output RDW, RegWriteW, ResultW,
    input  StallF, StallD, FlushD, FlushE,
    input  ForwardAE, ForwardBE, ResultW_q
  );

  modport slave (
    input  ValidD, RS1_D, RS2_D, UseRS1D, UseRS2D,
    input  RD_E, RegWriteE, ResultSrcE, PCSrcE,
    input  RD_M, RegWriteM,
    input  RDW, RegWriteW, ResultW,
    output StallF, StallD, FlushD, FlushE,
    output ForwardAE, ForwardBE, ResultW_q
  );
endinterface

// File: rtl/hazard_scheduler_20.sv
// hazard_scheduler_20
// Hazard unit for a five-stage pipeline with an 8-entry register file.
// - Detects load-use hazards and stalls fetch/decode while bubbling execute.
// - Flushes decode and execute on a taken branch; the branch wins over a stall.
// - Works out operand forward selects in decode and registers them so they
//   are valid while the consumer sits in execute.
// - Delays ResultW by one cycle so a producer that has just retired can
//   still be forwarded.
// Optional feature: define HAZ_PERF_CNT_EN to build saturating stall/flush
// performance counters. Without it the counter outputs are constant zero.
module hazard_scheduler_20 #(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  hazard_scheduler_20_if.slave bus,
  output logic [CNT_W-1:0]  StallCount,
  output logic [CNT_W-1:0]  FlushCount
);

  // Forward select encodings, named after the value the execute-stage mux
  // picks up.
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,  // register file read
    FWD_W   = 2'b01,  // ResultW (producer currently in M)
    FWD_M   = 2'b10,  // ALUResultM (producer currently in E)
    FWD_WQ  = 2'b11   // ResultW_q (producer currently in W)
  } fwd_sel_e;

  // A decode source depends on a producer when the decode slot is live, the
  // source is actually read, the addresses agree and the producer writes.
  // Register 0 is an ordinary register here, so it gets no special case.
  function automatic logic src_match(
    input logic       valid,
    input logic       use_src,
    input logic [2:0] src,
    input logic [2:0] dst,
    input logic       we
  );
    return valid & use_src & we & (src == dst);
  endfunction

  // Priority: an ALU result in E, then anything in M, then anything in W.
  // A load in E never selects FWD_M; that case is handled by the stall.
  function automatic fwd_sel_e fwd_select(
    input logic m_e_alu,
    input logic m_m,
    input logic m_w
  );
    if (m_e_alu)  return FWD_M;
    else if (m_m) return FWD_W;
    else if (m_w) return FWD_WQ;
    else          return FWD_RF;
  endfunction

  logic     rs1_match_e;
  logic     rs2_match_e;
  logic     rs1_match_m;
  logic     rs2_match_m;
  logic     rs1_match_w;
  logic     rs2_match_w;
  logic     load_use;
  logic     stall;
  fwd_sel_e fwd_a_next;
  fwd_sel_e fwd_b_next;
  fwd_sel_e fwd_a_q;
  fwd_sel_e fwd_b_q;
  logic [23:0] result_w_q;

  // Source-versus-producer address comparisons for every pipeline stage.
  always_comb begin
    rs1_match_e = src_match(bus.ValidD, bus.UseRS1D, bus.RS1_D, bus.RD_E, bus.RegWriteE);
    rs2_match_e = src_match(bus.ValidD, bus.UseRS2D, bus.RS2_D, bus.RD_E, bus.RegWriteE);
    rs1_match_m = src_match(bus.ValidD, bus.UseRS1D, bus.RS1_D, bus.RD_M, bus.RegWriteM);
    rs2_match_m = src_match(bus.ValidD, bus.UseRS2D, bus.RS2_D, bus.RD_M, bus.RegWriteM);
    rs1_match_w = src_match(bus.ValidD, bus.UseRS1D, bus.RS1_D, bus.RDW, bus.RegWriteW);
    rs2_match_w = src_match(bus.ValidD, bus.UseRS2D, bus.RS2_D, bus.RDW, bus.RegWriteW);
  end

  // Stall and flush controls. A taken branch discards the decode
  // instruction, so any load-use stall it would have caused is dropped.
  // The stall lasts one cycle on its own: on the next cycle the load has
  // moved to M and no longer matches E.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional logic, so no path can leave it unassigned and infer a latch.
    load_use   = 1'b0;
    stall      = 1'b0;
    bus.StallF = 1'b0;
    bus.StallD = 1'b0;
    bus.FlushD = 1'b0;
    bus.FlushE = 1'b0;

    load_use = bus.ResultSrcE & (rs1_match_e | rs2_match_e);
    stall    = load_use & ~bus.PCSrcE;

    if (bus.PCSrcE) begin
      bus.FlushD = 1'b1;
      bus.FlushE = 1'b1;
    end else if (stall) begin
      bus.StallF = 1'b1;
      bus.StallD = 1'b1;
      bus.FlushE = 1'b1;
    end
  end

  // Next forward selects for the instruction currently in decode.
  always_comb begin
    fwd_a_next = FWD_RF;
    fwd_b_next = FWD_RF;
    fwd_a_next = fwd_select(rs1_match_e & ~bus.ResultSrcE, rs1_match_m, rs1_match_w);
    fwd_b_next = fwd_select(rs2_match_e & ~bus.ResultSrcE, rs2_match_m, rs2_match_w);
  end

  // Execute-side forward select registers. A bubble entering execute
  // selects the register file. When decode is held they keep their value;
  // in practice a decode hold always comes with an execute bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else if (bus.FlushE) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples its pre-edge inputs, whatever order the blocks are evaluated in.
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else if (!bus.StallD) begin
      fwd_a_q <= fwd_a_next;
      fwd_b_q <= fwd_b_next;
    end
  end

  // One-cycle delayed writeback result. It captures on every edge so a
  // producer that has just left W stays reachable for forwarding.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) result_w_q <= '0;
    else      result_w_q <= bus.ResultW;
  end

  // Registered outputs onto the interface.
  always_comb begin
    bus.ForwardAE = fwd_a_q;
    bus.ForwardBE = fwd_b_q;
    bus.ResultW_q = result_w_q;
  end

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // Saturating counters: cycles spent stalling decode, and taken branches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (bus.StallD && (stall_cnt_q != {CNT_W{1'b1}}))
        stall_cnt_q <= stall_cnt_q + 1'b1;
      if (bus.PCSrcE && (flush_cnt_q != {CNT_W{1'b1}}))
        flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;
`else
  // The counters are not built; their outputs read as zero.
  assign StallCount = '0;
  assign FlushCount = '0;
`endif

endmodule

// File: tb/tb_hazard_scheduler_20.sv
// tb_hazard_scheduler_20
// Directed bench for hazard_scheduler_20 with hand-computed expectations.
// Inputs change 1 time unit after a rising edge. Combinational outputs are
// checked 1 unit after that, and registered outputs 1 unit after an edge.
module tb_hazard_scheduler_20;
  localparam int CNT_W = 4;
`ifdef HAZ_PERF_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [CNT_W-1:0] StallCount;
  logic [CNT_W-1:0] FlushCount;
  int               n_tests = 0;
  int               n_fail  = 0;

  hazard_scheduler_20_if bus ();

  hazard_scheduler_20 #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .StallCount (StallCount),
    .FlushCount (FlushCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_tests++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic idle();
    bus.ValidD     = 1'b0;
    bus.RS1_D      = 3'd0;
    bus.RS2_D      = 3'd0;
    bus.UseRS1D    = 1'b0;
    bus.UseRS2D    = 1'b0;
    bus.RD_E       = 3'd0;
    bus.RegWriteE  = 1'b0;
    bus.ResultSrcE = 1'b0;
    bus.PCSrcE     = 1'b0;
    bus.RD_M       = 3'd0;
    bus.RegWriteM  = 1'b0;
    bus.RDW        = 3'd0;
    bus.RegWriteW  = 1'b0;
    bus.ResultW    = 24'h0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Load of R3 in execute against a decode read of R3 on source 1.
  task automatic load_use_r3();
    idle();
    bus.ValidD     = 1'b1;
    bus.RS1_D      = 3'd3;
    bus.UseRS1D    = 1'b1;
    bus.RD_E       = 3'd3;
    bus.RegWriteE  = 1'b1;
    bus.ResultSrcE = 1'b1;
  endtask

  initial begin
    // ---- Reset state, with hazard inputs present during reset ----
    load_use_r3();
    bus.ResultW = 24'h123456;
    #2;
    check("rst_fwd_a",    bus.ForwardAE, 2'b00);
    check("rst_fwd_b",    bus.ForwardBE, 2'b00);
    check("rst_resq",     bus.ResultW_q, 24'h0);
    check("rst_stallcnt", StallCount, 4'h0);
    check("rst_flushcnt", FlushCount, 4'h0);
    check("rst_comb_stallf", bus.StallF, 1'b1);
    step();
    check("rst_resq_held", bus.ResultW_q, 24'h0);
    idle();
    rst = 1'b1;
    step();

    // ---- Load-use on R3: one-cycle stall, then forward from ResultW ----
    load_use_r3();
    #1;
    check("lu_stallf", bus.StallF, 1'b1);
    check("lu_stalld", bus.StallD, 1'b1);
    check("lu_flushe", bus.FlushE, 1'b1);
    check("lu_flushd", bus.FlushD, 1'b0);
    step();
    check("lu_fwd_a_bubble", bus.ForwardAE, 2'b00);
    bus.RegWriteE  = 1'b0;
    bus.ResultSrcE = 1'b0;
    bus.RD_M       = 3'd3;
    bus.RegWriteM  = 1'b1;
    #1;
    check("lu_released", bus.StallD, 1'b0);
    check("lu_flushe_off", bus.FlushE, 1'b0);
    step();
    check("lu_fwd_a", bus.ForwardAE, 2'b01);
    check("lu_fwd_b", bus.ForwardBE, 2'b00);

    // ---- ALU write of R5 in execute, decode reads R5 on source 2 ----
    idle();
    bus.ValidD    = 1'b1;
    bus.RS1_D     = 3'd1;
    bus.UseRS1D   = 1'b1;
    bus.RS2_D     = 3'd5;
    bus.UseRS2D   = 1'b1;
    bus.RD_E      = 3'd5;
    bus.RegWriteE = 1'b1;
    #1;
    check("alu_no_stall", bus.StallD, 1'b0);
    step();
    check("alu_fwd_b", bus.ForwardBE, 2'b10);
    check("alu_fwd_a", bus.ForwardAE, 2'b00);

    // ---- R2 written in both E and M: E has priority ----
    idle();
    bus.ValidD    = 1'b1;
    bus.RS1_D     = 3'd2;
    bus.UseRS1D   = 1'b1;
    bus.RD_E      = 3'd2;
    bus.RegWriteE = 1'b1;
    bus.RD_M      = 3'd2;
    bus.RegWriteM = 1'b1;
    step();
    check("prio_fwd_a", bus.ForwardAE, 2'b10);

    // ---- Writeback producer: forward from the delayed result ----
    idle();
    bus.ValidD    = 1'b1;
    bus.RS1_D     = 3'd4;
    bus.UseRS1D   = 1'b1;
    bus.RDW       = 3'd4;
    bus.RegWriteW = 1'b1;
    bus.ResultW   = 24'hABCDEF;
    step();
    check("wb_fwd_a", bus.ForwardAE, 2'b11);
    check("wb_resq",  bus.ResultW_q, 24'hABCDEF);

    // ---- Register 0 is forwarded like any other register ----
    idle();
    bus.ValidD    = 1'b1;
    bus.UseRS1D   = 1'b1;
    bus.UseRS2D   = 1'b1;
    bus.RD_M      = 3'd0;
    bus.RegWriteM = 1'b1;
    step();
    check("r0_fwd_a", bus.ForwardAE, 2'b01);
    check("r0_fwd_b", bus.ForwardBE, 2'b01);
    check("r0_resq_zero", bus.ResultW_q, 24'h0);

    // ---- Load-use and taken branch together: branch wins ----
    load_use_r3();
    bus.RS2_D   = 3'd3;
    bus.UseRS2D = 1'b1;
    bus.PCSrcE  = 1'b1;
    #1;
    check("br_flushd", bus.FlushD, 1'b1);
    check("br_flushe", bus.FlushE, 1'b1);
    check("br_stalld", bus.StallD, 1'b0);
    check("br_stallf", bus.StallF, 1'b0);
    step();
    check("br_fwd_a", bus.ForwardAE, 2'b00);
    check("br_fwd_b", bus.ForwardBE, 2'b00);
    check("br_stallcnt", StallCount, CNT_ON ? 4'h1 : 4'h0);
    check("br_flushcnt", FlushCount, CNT_ON ? 4'h1 : 4'h0);

    // ---- Qualifiers: unused source, invalid decode, load without write ----
    load_use_r3();
    bus.UseRS1D = 1'b0;
    #1;
    check("nouse_stalld", bus.StallD, 1'b0);
    bus.UseRS1D = 1'b1;
    bus.ValidD  = 1'b0;
    #1;
    check("novalid_stalld", bus.StallD, 1'b0);
    bus.ValidD    = 1'b1;
    bus.RegWriteE = 1'b0;
    #1;
    check("nowe_stalld", bus.StallD, 1'b0);
    bus.RS1_D = 3'd7;
    bus.RD_M  = 3'd7;
    bus.RegWriteM = 1'b1;
    step();
    check("m_over_w_fwd_a", bus.ForwardAE, 2'b01);

    // ---- Reset during a stall clears state at once; then recompute ----
    load_use_r3();
    bus.ResultW = 24'h00F00D;
    #1;
    check("mid_stall_on", bus.StallD, 1'b1);
    rst = 1'b0;
    #1;
    check("mid_rst_fwd_a", bus.ForwardAE, 2'b00);
    check("mid_rst_resq",  bus.ResultW_q, 24'h0);
    idle();
    step();
    rst = 1'b1;
    #1;
    check("post_rst_stalld", bus.StallD, 1'b0);
    step();
    check("post_rst_stallcnt", StallCount, 4'h0);

    // ---- 20 stall cycles saturate a 4-bit counter; reset clears it ----
    load_use_r3();
    for (int i = 0; i < 20; i++) step();
    check("sat_stallcnt", StallCount, CNT_ON ? 4'hF : 4'h0);
    check("sat_flushcnt", FlushCount, 4'h0);
    rst = 1'b0;
    #1;
    check("sat_rst_stallcnt", StallCount, 4'h0);
    check("sat_rst_comb_stalld", bus.StallD, 1'b1);
    idle();
    step();
    rst = 1'b1;
    step();
    check("end_stallcnt", StallCount, 4'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_scheduler_20.md
HAZARD_SCHEDULER_20 -- requirements
Module: hazard_scheduler_20

Interface
REQ-001 Parameter CNT_W, default 16, width of the performance counters.
REQ-002 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; asynchronous and active-low.
REQ-004 ValidD  input  1  decode stage holds a real instruction.
REQ-005 RS1_D, RS2_D  input  3 each  decode source register addresses (InstrD[28:26], InstrD[25:23]).
REQ-006 UseRS1D, UseRS2D  input  1 each  decode instruction reads that source.
REQ-007 RD_E  input  3  execute destination; RegWriteE, ResultSrcE  input  1 each  execute write enable, load flag.
REQ-008 RD_M  input  3  memory destination; RegWriteM  input  1.
REQ-009 RDW  input  3  writeback destination; RegWriteW  input  1; ResultW  input  24  writeback data.
REQ-010 PCSrcE  input  1  taken branch resolved in execute.
REQ-011 StallF, StallD  output  1 each  hold fetch PC, hold decode register.
REQ-012 FlushD, FlushE  output  1 each  bubble decode register, bubble execute register.
REQ-013 ForwardAE, ForwardBE  output  2 each  registered execute operand select: 00 RF, 01 ResultW, 10 ALUResultM, 11 ResultW_q.
REQ-014 ResultW_q  output  24  ResultW delayed one cycle.
REQ-015 StallCount, FlushCount  output  CNT_W each  performance counters.

Function
REQ-016 All 8 registers are real; address 0 gets no exemption in any comparison.
REQ-017 Source match = ValidD & UseRSxD & (RSx_D == producer address) & producer write enable.
REQ-018 Load-use hazard LU = source match against E with ResultSrcE=1, either source.
REQ-019 LU & !PCSrcE asserts StallF=1, StallD=1, FlushE=1 combinationally, same cycle.
REQ-020 PCSrcE=1 asserts FlushD=1, FlushE=1, StallF=0, StallD=0; branch overrides LU.
REQ-021 A load-use stall lasts exactly one cycle per load; next cycle the load is in M and LU is 0.
REQ-022 Forward selects are computed in decode and registered into the execute-side state each edge StallD=0.
REQ-023 Per source, priority: match E with ResultSrcE=0 -> 10; else match M -> 01; else match W -> 11; else 00.
REQ-024 Forward registers load 00 on any edge where FlushE=1.
REQ-025 ResultW_q captures ResultW every edge unconditionally.
REQ-026 Registered forward selects and ResultW_q are valid in the cycle the instruction occupies execute.

Reset
REQ-027 rst=0 asynchronously clears ForwardAE, ForwardBE to 00, ResultW_q to 0, counters to 0.
REQ-028 During reset combinational outputs reflect inputs; controlling logic gates ValidD low.
REQ-029 Reset mid-stall discards the stall; first cycle after release recomputes from inputs.

Configuration
REQ-030 Macro HAZ_PERF_CNT_EN defined: StallCount +1 per cycle with StallD=1, FlushCount +1 per cycle with PCSrcE=1, both saturate at all-ones.
REQ-031 HAZ_PERF_CNT_EN undefined: no counter flops; StallCount, FlushCount tied to 0.

Verification
REQ-032 Load R3 in E (ResultSrcE=1), decode RS1_D=3 UseRS1D=1 -> StallF=StallD=FlushE=1 one cycle; next edge ForwardAE=01.
REQ-033 ALU write R5 in E, decode RS2_D=5 -> next edge ForwardBE=10, ForwardAE=00.
REQ-034 R2 written in E and M simultaneously, decode RS1_D=2 -> ForwardAE=10 (E priority).
REQ-035 RegWriteW=1 RDW=4 ResultW=24'hABCDEF, decode RS1_D=4 -> next edge ForwardAE=11, ResultW_q=24'hABCDEF.
REQ-036 LU and PCSrcE same cycle -> FlushD=FlushE=1, StallD=0, forward registers 00, StallCount unchanged.
REQ-037 HAZ_PERF_CNT_EN, CNT_W=4, 20 stall cycles -> StallCount=4'hF; assert rst=0 mid-run -> 0 immediately.
